// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain engine for async_fifo (rd_clk domain).
// Pops words from the FIFO read port, absorbs the FIFO's one-cycle registered
// read latency in a 3-entry skid buffer and presents them as a valid/ready
// stream. m_last flags the final word of each PKT_LEN-word packet.
// The pop request depends only on registered state and fifo_empty, so there
// is no combinational path from m_ready to fifo_rd_en.
// Optional feature macro: RD_STREAM_STATS_EN adds the word_cnt and err_sticky outputs.
module fifo_rd_stream #(
    parameter int WIDTH   = 8,
    parameter int PKT_LEN = 4
) (
    input  logic             rd_clk,
    input  logic             rstn,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_empty,
    input  logic             fifo_almost_empty,
    input  logic             fifo_underflow,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
`ifdef RD_STREAM_STATS_EN
    output logic [15:0]      word_cnt,
    output logic             err_sticky,
`endif
    output logic             low_water
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        FETCH     = 2'b01,
        STALL     = 2'b10,
        IDLE_HOLD = 2'b11
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] skid_r [3];
    logic [1:0]       head_r;
    logic [1:0]       tail_r;
    logic [1:0]       occ_r;
    logic             inflight_r;
    logic             run_r;
    logic [7:0]       pkt_cnt_r;
    logic             low_water_r;
    logic [2:0]       fill_s;
    logic             pop_s;

    // Circular pointer advance over the three skid slots.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Slots already held plus the word the FIFO is about to return.
    assign fill_s  = {1'b0, occ_r} + {2'b00, inflight_r};
    assign m_valid = (occ_r != 2'd0);
    assign m_data  = skid_r[head_r];
    assign m_last  = m_valid && (pkt_cnt_r == LAST_IDX);
    assign pop_s   = m_valid && m_ready;
    // run_r keeps pops off until the first edge after reset release.
    assign fifo_rd_en = run_r && !fifo_empty && (fill_s < 3'd3) && (state_r != IDLE_HOLD);
    assign busy      = (state_r == FETCH) || (state_r == STALL);
    assign low_water = low_water_r;

    // State register plus pop enable and low-water flag.
    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            run_r       <= 1'b0;
            low_water_r <= 1'b0;
            inflight_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            run_r       <= 1'b1;
            low_water_r <= fifo_almost_empty;
            inflight_r  <= fifo_rd_en;
        end
    end

    // Next-state decode; the reserved encoding falls back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if ((fill_s == 3'd3) && !m_ready) begin
                    state_nxt_s = STALL;
                end else if (fifo_empty && (occ_r == 2'd0) && !inflight_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            STALL: begin
                if (m_ready && m_valid) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = STALL;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Skid buffer: capture returning FIFO data at the tail, pop at the head.
    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 3; i++) begin
                skid_r[i] <= '0;
            end
            head_r <= 2'd0;
            tail_r <= 2'd0;
            occ_r  <= 2'd0;
        end else begin
            if (inflight_r) begin
                skid_r[tail_r] <= fifo_rd_data;
                tail_r         <= next_ptr(tail_r);
            end
            if (pop_s) begin
                head_r <= next_ptr(head_r);
            end
            case ({inflight_r, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Packet position counter, advanced by each accepted word.
    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            pkt_cnt_r <= 8'd0;
        end else if (pop_s) begin
            if (pkt_cnt_r == LAST_IDX) begin
                pkt_cnt_r <= 8'd0;
            end else begin
                pkt_cnt_r <= pkt_cnt_r + 8'd1;
            end
        end
    end

`ifdef RD_STREAM_STATS_EN
    logic [15:0] word_cnt_r;
    logic        err_sticky_r;

    assign word_cnt   = word_cnt_r;
    assign err_sticky = err_sticky_r;

    // Delivered-word count and sticky underflow flag.
    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            word_cnt_r   <= 16'd0;
            err_sticky_r <= 1'b0;
        end else begin
            if (pop_s) begin
                word_cnt_r <= word_cnt_r + 16'd1;
            end
            if (fifo_underflow) begin
                err_sticky_r <= 1'b1;
            end
        end
    end
`else
    logic unused_underflow_s;
    assign unused_underflow_s = fifo_underflow;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: behavioural FIFOs feed a PKT_LEN=4 and a
// PKT_LEN=3 instance; expected words go into scoreboard queues and monitor
// processes compare every accepted stream word.
module tb_fifo_rd_stream;

    logic       rd_clk = 1'b0;
    logic       rstn;
    logic       m_ready;
    logic       m_ready3;
    logic       fifo_underflow;
    logic       fifo_almost_empty;
    logic       fifo_empty  = 1'b1;
    logic       fifo_empty3 = 1'b1;
    logic [7:0] fifo_rd_data  = 8'd0;
    logic [7:0] fifo_rd_data3 = 8'd0;

    logic       fifo_rd_en, m_valid, m_last, busy, low_water;
    logic [7:0] m_data;
    logic       fifo_rd_en3, m_valid3, m_last3, busy3, low_water3;
    logic [7:0] m_data3;
`ifdef RD_STREAM_STATS_EN
    logic [15:0] word_cnt, word_cnt3;
    logic        err_sticky, err_sticky3;
`endif

    logic [7:0] q[$];
    logic [7:0] q3[$];
    logic [8:0] exp_q[$];
    logic [8:0] exp_q3[$];
    int exp_pkt  = 0;
    int exp_pkt3 = 0;
    int tests_run    = 0;
    int tests_failed = 0;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_stream #(.WIDTH(8), .PKT_LEN(4)) u_dut (
        .rd_clk(rd_clk), .rstn(rstn), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
        .fifo_underflow(fifo_underflow), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_ready(m_ready), .busy(busy),
`ifdef RD_STREAM_STATS_EN
        .word_cnt(word_cnt), .err_sticky(err_sticky),
`endif
        .low_water(low_water)
    );

    fifo_rd_stream #(.WIDTH(8), .PKT_LEN(3)) u_dut3 (
        .rd_clk(rd_clk), .rstn(rstn), .fifo_rd_en(fifo_rd_en3), .fifo_rd_data(fifo_rd_data3),
        .fifo_empty(fifo_empty3), .fifo_almost_empty(1'b0),
        .fifo_underflow(1'b0), .m_valid(m_valid3), .m_data(m_data3), .m_last(m_last3),
        .m_ready(m_ready3), .busy(busy3),
`ifdef RD_STREAM_STATS_EN
        .word_cnt(word_cnt3), .err_sticky(err_sticky3),
`endif
        .low_water(low_water3)
    );

    // FIFO models: one-cycle registered read, empty flag updated at the edge.
    always @(posedge rd_clk) begin
        if (fifo_rd_en && (q.size() > 0)) fifo_rd_data <= q.pop_front();
        fifo_empty <= (q.size() == 0);
    end

    // Second FIFO model for the PKT_LEN=3 instance.
    always @(posedge rd_clk) begin
        if (fifo_rd_en3 && (q3.size() > 0)) fifo_rd_data3 <= q3.pop_front();
        fifo_empty3 <= (q3.size() == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [8:0] word);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: got word 0x%0h with nothing expected", name, word);
    endtask

    // Monitor for the PKT_LEN=4 stream.
    always @(negedge rd_clk) begin
        if (rstn === 1'b1 && m_valid && m_ready) begin
            if (exp_q.size() == 0) unexpected("stream_extra", {m_last, m_data});
            else check("stream_word", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
        end
    end

    // Monitor for the PKT_LEN=3 stream.
    always @(negedge rd_clk) begin
        if (rstn === 1'b1 && m_valid3 && m_ready3) begin
            if (exp_q3.size() == 0) unexpected("stream3_extra", {m_last3, m_data3});
            else check("stream3_word", 32'({m_last3, m_data3}), 32'(exp_q3.pop_front()));
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic expect_word(input logic [7:0] w);
        exp_q.push_back({(exp_pkt == 3), w});
        exp_pkt = (exp_pkt == 3) ? 0 : exp_pkt + 1;
    endtask

    task automatic push(input logic [7:0] w);
        q.push_back(w);
        expect_word(w);
    endtask

    task automatic push3(input logic [7:0] w);
        q3.push_back(w);
        exp_q3.push_back({(exp_pkt3 == 2), w});
        exp_pkt3 = (exp_pkt3 == 2) ? 0 : exp_pkt3 + 1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int pops, first_pop, last_pop, first_valid, valid_cnt;
        rstn = 1'b0; m_ready = 1'b1; m_ready3 = 1'b0;
        fifo_underflow = 1'b0; fifo_almost_empty = 1'b0;
        repeat (3) tick();
        check("reset_outputs", 32'({fifo_rd_en, m_valid, m_data, m_last, busy, low_water}), 32'd0);
        rstn = 1'b1;

        // Test 1: idle with an empty FIFO
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t1_idle", 32'({fifo_rd_en, m_valid, busy}), 32'd0);
        end

        // low_water is a registered copy of almost_empty
        fifo_almost_empty = 1'b1;
        tick();
        check("low_water_set", 32'(low_water), 32'd1);
        fifo_almost_empty = 1'b0;
        tick();
        check("low_water_clr", 32'(low_water), 32'd0);

        // Test 2: four preloaded words, m_ready=1
        for (int i = 0; i < 4; i++) push(8'(8'h11 + i));
        pops = 0; first_pop = -1; last_pop = -1; first_valid = -1; valid_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (fifo_rd_en) begin
                pops++;
                if (first_pop < 0) first_pop = i;
                last_pop = i;
            end
            if (m_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = i;
            end
        end
        check("t2_pops", 32'(pops), 32'd4);
        check("t2_pops_consecutive", 32'(last_pop - first_pop), 32'd3);
        check("t2_latency", 32'(first_valid - first_pop), 32'd2);
        check("t2_valid_cycles", 32'(valid_cnt), 32'd4);
        check("t2_drained", 32'(exp_q.size()), 32'd0);
        check("t2_idle_busy", 32'(busy), 32'd0);

        // Test 3: eight words with m_ready=0, then release
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
        pops = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (fifo_rd_en) pops++;
        end
        check("t3_stall_pops", 32'(pops), 32'd3);
        check("t3_head_hold", 32'({m_valid, m_data}), 32'h111);
        check("t3_state_stall", 32'(u_dut.state_r), 32'd2);
        check("t3_busy", 32'(busy), 32'd1);
        m_ready = 1'b1;
        valid_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (m_valid) valid_cnt++;
            tick();
        end
        check("t3_no_gaps", 32'(valid_cnt), 32'd8);
        check("t3_drained", 32'(exp_q.size()), 32'd0);

        // Test 4: PKT_LEN=3, seven words, toggling m_ready
        for (int i = 0; i < 7; i++) push3(8'(8'h21 + i));
        for (int i = 0; i < 100 && exp_q3.size() != 0; i++) begin
            m_ready3 = ~m_ready3;
            tick();
        end
        check("t4_drained", 32'(exp_q3.size()), 32'd0);
        check("t4_pkt_cnt", 32'(u_dut3.pkt_cnt_r), 32'd1);
        m_ready3 = 1'b0;

        // Test 5: reset while two words are held and one is in flight
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) q.push_back(8'(8'h31 + i));
        for (int i = 0; i < 20 && !(u_dut.occ_r == 2'd2 && u_dut.inflight_r); i++) tick();
        check("t5_reach_state", 32'({u_dut.occ_r, u_dut.inflight_r}), 32'h5);
        rstn = 1'b0;
        #1;
        check("t5_reset_outputs", 32'({fifo_rd_en, m_valid, m_data, m_last, busy, low_water}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_pop_in_reset", 32'(fifo_rd_en), 32'd0);
        end
        check("t5_fifo_left", 32'(q.size()), 32'd2);
        exp_pkt = 0; exp_pkt3 = 0;
        expect_word(8'h34);
        expect_word(8'h35);
        rstn = 1'b1;
        m_ready = 1'b1;
        wait_drain("t5_drained");

`ifdef RD_STREAM_STATS_EN
        // Test 6: statistics counters
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        exp_pkt = 0;
        for (int i = 0; i < 10; i++) push(8'(8'h41 + i));
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        wait_drain("t6_drained");
        tick();
        check("t6_word_cnt", 32'(word_cnt), 32'd10);
        check("t6_err_sticky", 32'(err_sticky), 32'd1);
        repeat (5) tick();
        check("t6_err_holds", 32'(err_sticky), 32'd1);
        rstn = 1'b0;
        #1;
        check("t6_stats_reset", 32'({word_cnt, err_sticky}), 32'd0);
        tick();
        rstn = 1'b1;
`endif

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
